// File: rtl/alu_dispatch_pkg.sv
// alu_dispatch_pkg: ALU op codes and RV32I opcode/funct constants shared by the dispatcher
package alu_dispatch_pkg;
  typedef enum logic [3:0] {
    ALU_OP_ADD  = 4'd0,
    ALU_OP_SUB  = 4'd1,
    ALU_OP_AND  = 4'd2,
    ALU_OP_OR   = 4'd3,
    ALU_OP_XOR  = 4'd4,
    ALU_OP_SLL  = 4'd5,
    ALU_OP_SRL  = 4'd6,
    ALU_OP_SAR  = 4'd7,
    ALU_OP_ADDI = 4'd8,
    ALU_OP_BEQ  = 4'd9,
    ALU_OP_BNE  = 4'd10,
    ALU_OP_BLT  = 4'd11,
    ALU_OP_BGE  = 4'd12
  } alu_op_e;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_XOR = 3'd4;
  localparam logic [2:0] F3_SR  = 3'd5;
  localparam logic [2:0] F3_OR  = 3'd6;
  localparam logic [2:0] F3_AND = 3'd7;
  localparam logic [2:0] F3_BEQ = 3'd0;
  localparam logic [2:0] F3_BNE = 3'd1;
  localparam logic [2:0] F3_BLT = 3'd4;
  localparam logic [2:0] F3_BGE = 3'd5;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
endpackage

// File: rtl/alu_dispatch_imm_gen.sv
// imm_gen: sign-extended I-format and B-format immediates from an RV32I word
module imm_gen #(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr_i,
  output logic [XLEN-1:0] i_imm_o,
  output logic [XLEN-1:0] b_imm_o
);
  logic unused_fields;
  assign unused_fields = ^{instr_i[19:12], instr_i[6:0]};
  assign i_imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
  assign b_imm_o = {{(XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
endmodule

// File: rtl/alu_dispatch.sv
// alu_dispatch: two-stage decode/writeback pipeline feeding an external combinational ALU
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_op,
  input  logic [XLEN-1:0] alu_c,
  input  logic            alu_f,
  output logic            wb_valid,
  input  logic            wb_ready,
  output logic [4:0]      wb_rd,
  output logic            wb_we,
  output logic [XLEN-1:0] wb_data,
  output logic            br_taken,
  output logic [XLEN-1:0] br_target,
  output logic            illegal
);
  logic [XLEN-1:0] i_imm, b_imm;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd;
  alu_op_e op_d, op_q;
  logic [XLEN-1:0] a_d, b_d, a_q, b_q, tgt_q;
  logic ill_d, br_d, d_full_q, d_ill_q, d_br_q, d_we_q, w_full_q;
  logic [4:0] d_rd_q;
  logic accept, d_to_w;
  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr_i(in_instr),
    .i_imm_o(i_imm),
    .b_imm_o(b_imm)
  );
  assign opc = in_instr[6:0];
  assign f3 = in_instr[14:12];
  assign f7 = in_instr[31:25];
  assign rd = in_instr[11:7];
  assign d_to_w = d_full_q && (!w_full_q || wb_ready);
  assign in_ready = !d_full_q || d_to_w;
  assign accept = in_valid && in_ready;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign wb_valid = w_full_q;
  // Decode the incoming bundle; anything unrecognised collapses to a zero-operand ADD
  always_comb begin
    op_d = ALU_OP_ADD;
    a_d = in_rs1;
    b_d = in_rs2;
    ill_d = 1'b0;
    br_d = 1'b0;
    if (opc == OPC_OP) begin
      case (f3)
        F3_ADD: op_d = f7[5] ? ALU_OP_SUB : ALU_OP_ADD;
        F3_SLL: op_d = ALU_OP_SLL;
        F3_XOR: op_d = ALU_OP_XOR;
        F3_SR:  op_d = f7[5] ? ALU_OP_SAR : ALU_OP_SRL;
        F3_OR:  op_d = ALU_OP_OR;
        F3_AND: op_d = ALU_OP_AND;
        default: ill_d = 1'b1;
      endcase
      if (f7 != F7_BASE && !(f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR))) ill_d = 1'b1;
    end else if (opc == OPC_OP_IMM) begin
      b_d = i_imm;
      case (f3)
        F3_ADD: begin op_d = ALU_OP_ADDI; b_d = XLEN'(in_instr[31:20]); end
        F3_SLL: begin op_d = ALU_OP_SLL; ill_d = f7 != F7_BASE; end
        F3_XOR: op_d = ALU_OP_XOR;
        F3_SR:  begin op_d = f7[5] ? ALU_OP_SAR : ALU_OP_SRL; ill_d = f7 != F7_BASE && f7 != F7_ALT; end
        F3_OR:  op_d = ALU_OP_OR;
        F3_AND: op_d = ALU_OP_AND;
        default: ill_d = 1'b1;
      endcase
    end else if (opc == OPC_BRANCH) begin
      br_d = 1'b1;
      case (f3)
        F3_BEQ: op_d = ALU_OP_BEQ;
        F3_BNE: op_d = ALU_OP_BNE;
        F3_BLT: op_d = ALU_OP_BLT;
        F3_BGE: op_d = ALU_OP_BGE;
        default: ill_d = 1'b1;
      endcase
    end else begin
      ill_d = 1'b1;
    end
    if (ill_d) begin
      op_d = ALU_OP_ADD;
      a_d = '0;
      b_d = '0;
      br_d = 1'b0;
    end
  end
  // D stage: hold the decoded bundle so the ALU sees flop-driven operands
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d_full_q <= 1'b0;
      op_q <= ALU_OP_ADD;
      a_q <= '0;
      b_q <= '0;
      tgt_q <= '0;
      d_rd_q <= '0;
      d_we_q <= 1'b0;
      d_br_q <= 1'b0;
      d_ill_q <= 1'b0;
    end else begin
      d_full_q <= accept || (d_full_q && !d_to_w);
      if (accept) begin
        op_q <= op_d;
        a_q <= a_d;
        b_q <= b_d;
        tgt_q <= br_d ? in_pc + b_imm : '0;
        d_rd_q <= rd;
        d_we_q <= !ill_d && !br_d && rd != 5'd0;
        d_br_q <= br_d;
        d_ill_q <= ill_d;
      end
    end
  end
  // W stage: capture the ALU result and hold it until the consumer takes it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_full_q <= 1'b0;
      wb_rd <= '0;
      wb_we <= 1'b0;
      wb_data <= '0;
      br_taken <= 1'b0;
      br_target <= '0;
      illegal <= 1'b0;
    end else begin
      w_full_q <= d_to_w || (w_full_q && !wb_ready);
      if (d_to_w) begin
        wb_rd <= d_rd_q;
        wb_we <= d_we_q;
        wb_data <= alu_c;
        br_taken <= d_br_q && alu_f;
        br_target <= tgt_q;
        illegal <= d_ill_q;
      end
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: directed vectors against alu_dispatch with a behavioural external ALU
module tb_alu_dispatch;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, alu_f, wb_valid, wb_ready, wb_we, br_taken, illegal;
  logic [31:0] in_instr, in_rs1, in_rs2, in_pc, alu_a, alu_b, alu_c, wb_data, br_target;
  logic [3:0] alu_op;
  logic [4:0] wb_rd;
  int n_checks = 0;
  int n_fails = 0;

  alu_dispatch #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_pc(in_pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c), .alu_f(alu_f),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_we(wb_we),
    .wb_data(wb_data), .br_taken(br_taken), .br_target(br_target), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // External ALU: ADDI sign-extends the raw 12-bit immediate, branches report compare in alu_f
  always_comb begin
    alu_c = alu_a - alu_b;
    alu_f = 1'b0;
    case (alu_op)
      4'd0: alu_c = alu_a + alu_b;
      4'd1: alu_c = alu_a - alu_b;
      4'd2: alu_c = alu_a & alu_b;
      4'd3: alu_c = alu_a | alu_b;
      4'd4: alu_c = alu_a ^ alu_b;
      4'd5: alu_c = alu_a << alu_b[4:0];
      4'd6: alu_c = alu_a >> alu_b[4:0];
      4'd7: alu_c = $signed(alu_a) >>> alu_b[4:0];
      4'd8: alu_c = alu_a + {{20{alu_b[11]}}, alu_b[11:0]};
      4'd9: alu_f = alu_a == alu_b;
      4'd10: alu_f = alu_a != alu_b;
      4'd11: alu_f = $signed(alu_a) < $signed(alu_b);
      4'd12: alu_f = $signed(alu_a) >= $signed(alu_b);
      default: alu_c = '0;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] i_ins(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
    return {imm, 5'd1, f3, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] b_ins(input logic [12:0] im, input logic [2:0] f3);
    return {im[12], im[10:5], 5'd2, 5'd1, f3, im[4:1], im[11], 7'b1100011};
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_rs1 = r1;
    in_rs2 = r2;
    in_pc = pc;
  endtask

  // Present one bundle for a single cycle; on return it sits in D
  task automatic issue(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] pc);
    drive(ins, r1, r2, pc);
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_instr = '0;
    in_rs1 = '0;
    in_rs2 = '0;
    in_pc = '0;
    wb_ready = 1'b1;
    step();
    step();
    check("rst_wb_valid", wb_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_br_target", br_target, 0);
    check("rst_illegal", illegal, 0);
    rst_n = 1'b1;
    step();

    issue(r_ins(7'h00, 3'd0, 5'd3), 32'd5, 32'd7, 32'h0);
    check("add_op", alu_op, 0);
    check("add_a", alu_a, 5);
    check("add_b", alu_b, 7);
    check("add_early_valid", wb_valid, 0);
    step();
    check("add_valid", wb_valid, 1);
    check("add_rd", wb_rd, 3);
    check("add_we", wb_we, 1);
    check("add_data", wb_data, 12);
    check("add_taken", br_taken, 0);
    step();
    check("add_drained", wb_valid, 0);

    issue(r_ins(7'h20, 3'd0, 5'd5), 32'd10, 32'd3, 32'h0);
    check("sub_op", alu_op, 1);
    step();
    check("sub_data", wb_data, 7);
    step();

    issue(i_ins(12'hFFF, 3'd0, 5'd1), 32'd0, 32'd99, 32'h0);
    check("addi_op", alu_op, 8);
    check("addi_b", alu_b, 32'h00000FFF);
    step();
    check("addi_data", wb_data, 32'hFFFFFFFF);
    check("addi_we", wb_we, 1);
    step();

    issue(i_ins(12'h404, 3'd5, 5'd2), 32'h80000000, 32'd0, 32'h0);
    check("srai_op", alu_op, 7);
    check("srai_b", alu_b, 32'h404);
    step();
    check("srai_data", wb_data, 32'hF8000000);
    step();

    issue(b_ins(13'd16, 3'd0), 32'd4, 32'd4, 32'h100);
    check("beq_op", alu_op, 9);
    check("beq_a", alu_a, 4);
    step();
    check("beq_taken", br_taken, 1);
    check("beq_target", br_target, 32'h110);
    check("beq_we", wb_we, 0);
    step();

    issue(b_ins(13'd16, 3'd1), 32'd4, 32'd4, 32'h100);
    check("bne_op", alu_op, 10);
    step();
    check("bne_taken", br_taken, 0);
    check("bne_target", br_target, 32'h110);
    step();

    issue(b_ins(13'h1FF8, 3'd4), 32'hFFFFFFFF, 32'd1, 32'h100);
    step();
    check("blt_taken", br_taken, 1);
    check("blt_target", br_target, 32'hF8);
    step();

    issue(32'hFFFFFFFF, 32'd9, 32'd9, 32'h0);
    check("ill_op", alu_op, 0);
    check("ill_a", alu_a, 0);
    check("ill_b", alu_b, 0);
    step();
    check("ill_flag", illegal, 1);
    check("ill_we", wb_we, 0);
    check("ill_taken", br_taken, 0);
    step();

    issue(r_ins(7'h00, 3'd2, 5'd4), 32'd1, 32'd2, 32'h0);
    step();
    check("slt_illegal", illegal, 1);
    step();

    issue(r_ins(7'h00, 3'd0, 5'd0), 32'd1, 32'd1, 32'h0);
    step();
    check("x0_we", wb_we, 0);
    check("x0_illegal", illegal, 0);
    check("x0_data", wb_data, 2);
    step();

    for (int k = 0; k < 4; k++) begin
      drive(r_ins(7'h00, 3'd0, 5'(k + 1)), 32'(k * 10), 32'd1, 32'h0);
      check("b2b_in_ready", in_ready, 1);
      step();
      if (k >= 1) begin
        check("b2b_valid", wb_valid, 1);
        check("b2b_rd", wb_rd, 64'(k));
        check("b2b_data", wb_data, 64'((k - 1) * 10 + 1));
      end
    end
    in_valid = 1'b0;
    step();
    check("b2b_last_valid", wb_valid, 1);
    check("b2b_last_rd", wb_rd, 4);
    check("b2b_last_data", wb_data, 31);
    step();
    check("b2b_drained", wb_valid, 0);

    wb_ready = 1'b0;
    drive(r_ins(7'h00, 3'd0, 5'd10), 32'd100, 32'd1, 32'h0);
    check("stall_rdy_a", in_ready, 1);
    step();
    drive(r_ins(7'h00, 3'd0, 5'd11), 32'd200, 32'd1, 32'h0);
    check("stall_rdy_b", in_ready, 1);
    step();
    drive(r_ins(7'h00, 3'd0, 5'd12), 32'd300, 32'd1, 32'h0);
    for (int s = 0; s < 3; s++) begin
      check("stall_in_ready", in_ready, 0);
      check("stall_valid", wb_valid, 1);
      check("stall_rd", wb_rd, 10);
      check("stall_data", wb_data, 101);
      if (s < 2) step();
    end
    wb_ready = 1'b1;
    #1;
    check("stall_release_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    check("order_b_rd", wb_rd, 11);
    check("order_b_data", wb_data, 201);
    step();
    check("order_c_rd", wb_rd, 12);
    check("order_c_data", wb_data, 301);
    step();
    check("order_drained", wb_valid, 0);

    wb_ready = 1'b0;
    drive(r_ins(7'h00, 3'd0, 5'd7), 32'd1, 32'd1, 32'h0);
    step();
    drive(r_ins(7'h00, 3'd0, 5'd8), 32'd2, 32'd2, 32'h0);
    step();
    in_valid = 1'b0;
    check("full_valid", wb_valid, 1);
    check("full_in_ready", in_ready, 0);
    rst_n = 1'b0;
    step();
    check("midrst_valid", wb_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_wb_data", wb_data, 0);
    rst_n = 1'b1;
    wb_ready = 1'b1;
    for (int s = 0; s < 3; s++) begin
      step();
      check("post_rst_no_valid", wb_valid, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
